m_shift_unit: RTL and testbench
===============================

Name: m_shift_unit

Overview:
- Parametrised, pipelined execute-stage shift unit.
- Consumes the operation kind and shift amount produced by the decoder's shift field, plus an operand, and produces the shifted result.
- Generalises the fixed 32-bit / 5-bit-amount shift encoding to any power-of-two width, adds rotates, and uses a configurable pipeline depth with valid/ready flow control.
- Sits between the register-read stage and writeback in the integer pipeline.

Parameters:
- WIDTH, 32, operand/result width in bits; power of two, minimum 8.
- STAGES, 2, pipeline register stages; range 1..$clog2(WIDTH); equals latency in cycles.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- flush  input  1  synchronous kill of all in-flight operations.
- in_valid  input  1  input operation present.
- in_ready  output  1  unit accepts input this cycle.
- in_kind  input  3  0=SHL, 1=SHR, 2=SAR, 3=ROL, 4=ROR; 5..7 invalid.
- in_amount  input  $clog2(WIDTH)  shift/rotate distance.
- in_data  input  WIDTH  operand.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  result.
- out_error  output  1  operation had an invalid kind.

Behaviour:
- Reset: when rst_n=0 at a rising edge, all stage valid bits, out_valid, out_data and out_error clear to 0. in_ready is combinational and reads 1 while the pipe is empty.
- Structure: logarithmic shifter with $clog2(WIDTH) mux levels. Levels are split across STAGES register stages in ascending amount-bit order; each stage holds ceil(levels/STAGES) levels and the last stage takes the remainder.
- Each stage register carries: valid, kind, remaining amount bits, partial data, error.
- Advance rule: advance = !out_valid || out_ready. All stages move together when advance=1 and all hold when advance=0. There is no bubble collapse.
- in_ready = advance. A transfer occurs when in_valid && in_ready.
- Latency: a transfer at cycle N gives out_valid=1 at cycle N+STAGES, provided advance stays 1.
- Throughput: one operation per cycle while out_ready=1.
- Order: results are always delivered in input order.
- SHL / SHR: fill with 0.
- SAR: fill with in_data[WIDTH-1].
- ROL / ROR: bits wrap modulo WIDTH.
- Amount 0: out_data = in_data for all valid kinds.
- Amount width: out-of-range amounts cannot be expressed; the amount is always interpreted mod WIDTH.
- Invalid kind: out_error=1, out_data=0. The operation still occupies its slot and still follows the handshake.
- Holding: while out_valid=1 and out_ready=0, out_data and out_error stay stable.
- flush=1: every stage valid bit and out_valid clear at the edge; data registers may keep stale values. An input presented in the flush cycle is discarded.
- Priority: rst_n low takes priority over flush, and flush takes priority over a transfer.
- Mid-operation reset or flush: no partial result is ever emitted afterwards.
- out_error and out_data are only meaningful while out_valid=1.

Optional Feature:
- Macro: SHIFT_UNIT_FLAGS_EN.
- When defined, two extra output ports exist:
  - out_zero (1 bit): 1 when out_data==0.
  - out_carry (1 bit): the last bit shifted or rotated out. For SHL this is in_data[WIDTH-amount]; for SHR/SAR it is in_data[amount-1]; for ROL it is result[0]; for ROR it is result[WIDTH-1]. It is 0 when amount=0 or the kind is invalid.
- Both flags are registered alongside out_data, reset to 0, and are stable under stall.
- When undefined, the ports do not exist and there is no flag logic.

Test Plan:
- WIDTH=32, STAGES=2, reset held 2 cycles then released -> out_valid=0 and in_ready=1. Then SHL 0x00000001 by 0 -> out_data=0x00000001 exactly 2 cycles after the transfer.
- SAR 0x80000000 by 31 -> 0xFFFFFFFF; SHR 0x80000000 by 31 -> 0x00000001; ROR 0x80000001 by 1 -> 0xC0000000; ROL 0x80000001 by 4 -> 0x00000018.
- Kind=7, data 0x12345678, amount 3 -> out_valid=1, out_error=1, out_data=0. The next valid op returns out_error=0.
- Back-to-back SHL 0x1 by 1, 2, 3, with out_ready=0 for 4 cycles after the first result -> in_ready=0 during the stall, results stay stable, then 0x2, 0x4, 0x8 arrive in order on consecutive cycles.
- Two ops in flight, flush=1 for 1 cycle -> no out_valid for either op. A new op issued the following cycle completes normally after 2 cycles.
- With SHIFT_UNIT_FLAGS_EN: SHL 0x80000000 by 1 -> out_data=0, out_zero=1, out_carry=1. Repeat the ops with STAGES=1 and STAGES=5 -> identical results at latency 1 and 5.

Source files
------------

// File: rtl/m_shift_unit.sv
// m_shift_unit: pipelined logarithmic shift/rotate unit (SHL/SHR/SAR/ROL/ROR) with valid/ready flow control.
// Define SHIFT_UNIT_FLAGS_EN to add the registered out_zero / out_carry result flags.
module m_shift_unit #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_kind,
    input  logic [$clog2(WIDTH)-1:0] in_amount,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_error
`ifdef SHIFT_UNIT_FLAGS_EN
   ,output logic                     out_zero,
    output logic                     out_carry
`endif
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int LPS    = (LEVELS + STAGES - 1) / STAGES;

    localparam logic [2:0] K_SHL = 3'd0;
    localparam logic [2:0] K_SHR = 3'd1;
    localparam logic [2:0] K_SAR = 3'd2;
    localparam logic [2:0] K_ROL = 3'd3;
    localparam logic [2:0] K_ROR = 3'd4;

    // One mux level: conditional move by 2**l. Invalid kinds pass the (already zeroed) data through.
    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       kind,
        input int               l
    );
        int k;
        k = 1 << l;
        case (kind)
            K_SHL:   shift_level = d << k;
            K_SHR:   shift_level = d >> k;
            K_SAR:   shift_level = $unsigned($signed(d) >>> k);
            K_ROL:   shift_level = (d << k) | (d >> (WIDTH - k));
            K_ROR:   shift_level = (d >> k) | (d << (WIDTH - k));
            default: shift_level = d;
        endcase
    endfunction

    logic             advance;
    logic             kind_ok;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_error_reg;

    // Inputs seen by each stage: port side for stage 0, previous register otherwise.
    logic              sv_in [STAGES];
    logic [2:0]        sk_in [STAGES];
    logic [LEVELS-1:0] sa_in [STAGES];
    logic [WIDTH-1:0]  sd_in [STAGES];
    logic              se_in [STAGES];

    assign advance   = !out_valid_reg || out_ready;
    assign in_ready  = advance;
    assign kind_ok   = (in_kind <= K_ROR);

    assign sv_in[0]  = in_valid;
    assign sk_in[0]  = in_kind;
    assign sa_in[0]  = in_amount;
    assign sd_in[0]  = kind_ok ? in_data : '0;
    assign se_in[0]  = !kind_ok;

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_error = out_error_reg;

`ifdef SHIFT_UNIT_FLAGS_EN
    // Shift carry depends only on the operand, so it is picked up front; rotate carry
    // is a bit of the final result and is resolved in the last stage.
    logic              sc_in [STAGES];
    logic              sr_in [STAGES];
    logic [LEVELS-1:0] amt_neg;
    logic [LEVELS-1:0] amt_dec;
    logic              out_zero_reg;
    logic              out_carry_reg;

    assign amt_neg  = -in_amount;
    assign amt_dec  = in_amount - LEVELS'(1);
    assign sc_in[0] = (in_amount == '0)                           ? 1'b0 :
                      (in_kind == K_SHL)                          ? in_data[amt_neg] :
                      ((in_kind == K_SHR) || (in_kind == K_SAR))  ? in_data[amt_dec] :
                                                                    1'b0;
    assign sr_in[0] = (in_amount != '0) && ((in_kind == K_ROL) || (in_kind == K_ROR));

    assign out_zero  = out_zero_reg;
    assign out_carry = out_carry_reg;
`endif

    genvar gi, gj;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int LO = gi * LPS;

            logic [WIDTH-1:0] lvl [LPS+1];

            assign lvl[0] = sd_in[gi];

            // Stage gi owns amount bits LO .. LO+LPS-1; bits beyond LEVELS are pass-through.
            for (gj = 0; gj < LPS; gj++) begin : g_level
                if (LO + gj < LEVELS) begin : g_mux
                    assign lvl[gj+1] = sa_in[gi][LO+gj] ?
                                       shift_level(lvl[gj], sk_in[gi], LO + gj) : lvl[gj];
                end else begin : g_pass
                    assign lvl[gj+1] = lvl[gj];
                end
            end

            if (gi == STAGES - 1) begin : g_last
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        out_valid_reg <= 1'b0;
                        out_data_reg  <= '0;
                        out_error_reg <= 1'b0;
                    end else if (flush) begin
                        out_valid_reg <= 1'b0;
                    end else if (advance) begin
                        out_valid_reg <= sv_in[gi];
                        out_data_reg  <= lvl[LPS];
                        out_error_reg <= se_in[gi];
                    end
                end

`ifdef SHIFT_UNIT_FLAGS_EN
                logic carry_next;

                assign carry_next = !sr_in[gi]          ? sc_in[gi] :
                                    (sk_in[gi] == K_ROL) ? lvl[LPS][0] :
                                                           lvl[LPS][WIDTH-1];

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        out_zero_reg  <= 1'b0;
                        out_carry_reg <= 1'b0;
                    end else if (!flush && advance) begin
                        out_zero_reg  <= (lvl[LPS] == '0);
                        out_carry_reg <= carry_next;
                    end
                end
`endif
            end else begin : g_mid
                logic              valid_reg;
                logic [2:0]        kind_reg;
                logic [LEVELS-1:0] amount_reg;
                logic [WIDTH-1:0]  data_reg;
                logic              error_reg;

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        valid_reg  <= 1'b0;
                        kind_reg   <= '0;
                        amount_reg <= '0;
                        data_reg   <= '0;
                        error_reg  <= 1'b0;
                    end else if (flush) begin
                        valid_reg  <= 1'b0;
                    end else if (advance) begin
                        valid_reg  <= sv_in[gi];
                        kind_reg   <= sk_in[gi];
                        amount_reg <= sa_in[gi];
                        data_reg   <= lvl[LPS];
                        error_reg  <= se_in[gi];
                    end
                end

                assign sv_in[gi+1] = valid_reg;
                assign sk_in[gi+1] = kind_reg;
                assign sa_in[gi+1] = amount_reg;
                assign sd_in[gi+1] = data_reg;
                assign se_in[gi+1] = error_reg;

`ifdef SHIFT_UNIT_FLAGS_EN
                logic carry_reg;
                logic rot_reg;

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        carry_reg <= 1'b0;
                        rot_reg   <= 1'b0;
                    end else if (!flush && advance) begin
                        carry_reg <= sc_in[gi];
                        rot_reg   <= sr_in[gi];
                    end
                end

                assign sc_in[gi+1] = carry_reg;
                assign sr_in[gi+1] = rot_reg;
`endif
            end
        end
    endgenerate

endmodule

// File: tb/tb_m_shift_unit.sv
// Self-checking bench for m_shift_unit: three instances (STAGES 1, 2, 5) share stimulus and are
// compared every cycle against a slot-queue model with an arithmetic reference for each operation.
`timescale 1ns/1ps
module tb_m_shift_unit;
    localparam int ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  in_kind;
    logic [4:0]  in_amount;
    logic [31:0] in_data;

    logic        in_ready_d  [ND];
    logic        out_valid_d [ND];
    logic [31:0] out_data_d  [ND];
    logic        out_error_d [ND];
`ifdef SHIFT_UNIT_FLAGS_EN
    logic        out_zero_d  [ND];
    logic        out_carry_d [ND];
`endif

    int checks = 0;
    int errors = 0;

    // Model: per instance, a row of pipeline slots; slot lat-1 is what the output should show.
    logic        mv [ND][5];
    logic [31:0] md [ND][5];
    logic        me [ND][5];
    logic        mz [ND][5];
    logic        mc [ND][5];

    m_shift_unit #(.WIDTH(32), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_d[0]),
        .in_kind(in_kind), .in_amount(in_amount), .in_data(in_data), .out_valid(out_valid_d[0]),
        .out_ready(out_ready), .out_data(out_data_d[0]), .out_error(out_error_d[0])
`ifdef SHIFT_UNIT_FLAGS_EN
       ,.out_zero(out_zero_d[0]), .out_carry(out_carry_d[0])
`endif
    );

    m_shift_unit #(.WIDTH(32), .STAGES(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_d[1]),
        .in_kind(in_kind), .in_amount(in_amount), .in_data(in_data), .out_valid(out_valid_d[1]),
        .out_ready(out_ready), .out_data(out_data_d[1]), .out_error(out_error_d[1])
`ifdef SHIFT_UNIT_FLAGS_EN
       ,.out_zero(out_zero_d[1]), .out_carry(out_carry_d[1])
`endif
    );

    m_shift_unit #(.WIDTH(32), .STAGES(5)) u_s5 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_d[2]),
        .in_kind(in_kind), .in_amount(in_amount), .in_data(in_data), .out_valid(out_valid_d[2]),
        .out_ready(out_ready), .out_data(out_data_d[2]), .out_error(out_error_d[2])
`ifdef SHIFT_UNIT_FLAGS_EN
       ,.out_zero(out_zero_d[2]), .out_carry(out_carry_d[2])
`endif
    );

    function automatic int lat_of(input int d);
        if (d == 0) return 1;
        if (d == 1) return 2;
        return 5;
    endfunction

    function automatic string tg(input string name, input int d);
        return $sformatf("u%0d_%s", lat_of(d), name);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference operation from the plain definition of each kind, using 64-bit arithmetic.
    task automatic ref_op(input logic [2:0] k, input logic [4:0] a, input logic [31:0] d,
                          output logic [31:0] r, output logic e, output logic c);
        logic [63:0] t;
        r = '0;
        e = 1'b0;
        c = 1'b0;
        case (k)
            3'd0: begin t = {32'd0, d} << a;                r = t[31:0];  c = t[32]; end
            3'd1: begin t = {d, 32'd0} >> a;                r = t[63:32]; c = t[31]; end
            3'd2: begin t = 64'($signed({d, 32'd0}) >>> a); r = t[63:32]; c = t[31]; end
            3'd3: begin t = {d, d} << a;                    r = t[63:32]; c = (a != 5'd0) && r[0]; end
            3'd4: begin t = {d, d} >> a;                    r = t[31:0];  c = (a != 5'd0) && r[31]; end
            default: e = 1'b1;
        endcase
    endtask

    task automatic model_tick();
        logic [31:0] r;
        logic        e;
        logic        c;
        for (int d = 0; d < ND; d++) begin
            int  n;
            bit  adv;
            n   = lat_of(d);
            adv = !mv[d][n-1] || out_ready;
            if (!rst_n) begin
                for (int s = 0; s < 5; s++) mv[d][s] = 1'b0;
                md[d][n-1] = '0;
                me[d][n-1] = 1'b0;
                mz[d][n-1] = 1'b0;
                mc[d][n-1] = 1'b0;
            end else if (flush) begin
                for (int s = 0; s < 5; s++) mv[d][s] = 1'b0;
            end else if (adv) begin
                for (int s = n - 1; s > 0; s--) begin
                    mv[d][s] = mv[d][s-1];
                    md[d][s] = md[d][s-1];
                    me[d][s] = me[d][s-1];
                    mz[d][s] = mz[d][s-1];
                    mc[d][s] = mc[d][s-1];
                end
                ref_op(in_kind, in_amount, in_data, r, e, c);
                mv[d][0] = in_valid;
                md[d][0] = r;
                me[d][0] = e;
                mz[d][0] = (r == 32'd0);
                mc[d][0] = c;
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < ND; d++) begin
            int n;
            n = lat_of(d);
            check(tg("valid", d), 32'(out_valid_d[d]), 32'(mv[d][n-1]));
            check(tg("in_ready", d), 32'(in_ready_d[d]), 32'(!mv[d][n-1] || out_ready));
            if (mv[d][n-1]) begin
                check(tg("data", d), out_data_d[d], md[d][n-1]);
                check(tg("error", d), 32'(out_error_d[d]), 32'(me[d][n-1]));
`ifdef SHIFT_UNIT_FLAGS_EN
                check(tg("zero", d), 32'(out_zero_d[d]), 32'(mz[d][n-1]));
                check(tg("carry", d), 32'(out_carry_d[d]), 32'(mc[d][n-1]));
`endif
            end
        end
    endtask

    task automatic step();
        model_tick();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    // Issue one op alone and check each instance shows it exactly at its latency.
    task automatic run_vec(input string name, input logic [2:0] k, input logic [4:0] a,
                           input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e);
        in_kind   = k;
        in_amount = a;
        in_data   = d;
        in_valid  = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            in_valid = 1'b0;
            for (int u = 0; u < ND; u++) begin
                if (c < lat_of(u)) begin
                    check(tg({name, "_early"}, u), 32'(out_valid_d[u]), 32'd0);
                end else if (c == lat_of(u)) begin
                    check(tg({name, "_valid"}, u), 32'(out_valid_d[u]), 32'd1);
                    check(tg({name, "_data"}, u), out_data_d[u], exp_d);
                    check(tg({name, "_err"}, u), 32'(out_error_d[u]), 32'(exp_e));
`ifdef SHIFT_UNIT_FLAGS_EN
                    check(tg({name, "_zero"}, u), 32'(out_zero_d[u]), 32'(exp_d == 32'd0));
`endif
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_kind   = 3'd0;
        in_amount = 5'd0;
        in_data   = 32'd0;

        step();
        step();
        for (int u = 0; u < ND; u++) begin
            check(tg("rst_valid", u), 32'(out_valid_d[u]), 32'd0);
            check(tg("rst_in_ready", u), 32'(in_ready_d[u]), 32'd1);
            check(tg("rst_data", u), out_data_d[u], 32'd0);
            check(tg("rst_error", u), 32'(out_error_d[u]), 32'd0);
        end
        rst_n = 1'b1;
        idle(1);

        run_vec("shl0", 3'd0, 5'd0,  32'h0000_0001, 32'h0000_0001, 1'b0);
        run_vec("sar31", 3'd2, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_vec("shr31", 3'd1, 5'd31, 32'h8000_0000, 32'h0000_0001, 1'b0);
        run_vec("ror1", 3'd4, 5'd1,  32'h8000_0001, 32'hC000_0000, 1'b0);
        run_vec("rol4", 3'd3, 5'd4,  32'h8000_0001, 32'h0000_0018, 1'b0);
        run_vec("bad7", 3'd7, 5'd3,  32'h1234_5678, 32'h0000_0000, 1'b1);
        run_vec("shlmsb", 3'd0, 5'd1, 32'h8000_0000, 32'h0000_0000, 1'b0);
        run_vec("sar0", 3'd2, 5'd0,  32'h8765_4321, 32'h8765_4321, 1'b0);

`ifdef SHIFT_UNIT_FLAGS_EN
        in_kind = 3'd0; in_amount = 5'd1; in_data = 32'h8000_0000; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("u2_flag_zero", 32'(out_zero_d[1]), 32'd1);
        check("u2_flag_carry", 32'(out_carry_d[1]), 32'd1);
        idle(5);
`endif

        // Back-to-back ops with a 4-cycle consumer stall after the first result.
        in_kind = 3'd0; in_data = 32'h1; in_amount = 5'd1; in_valid = 1'b1;
        step();
        in_amount = 5'd2;
        step();
        check("stall_first_data", out_data_d[1], 32'h2);
        out_ready = 1'b0;
        in_amount = 5'd3;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_in_ready", 32'(in_ready_d[1]), 32'd0);
            check("stall_valid", 32'(out_valid_d[1]), 32'd1);
            check("stall_data", out_data_d[1], 32'h2);
        end
        out_ready = 1'b1;
        step();
        check("stall_second", out_data_d[1], 32'h4);
        in_valid = 1'b0;
        step();
        check("stall_third_valid", 32'(out_valid_d[1]), 32'd1);
        check("stall_third", out_data_d[1], 32'h8);
        idle(7);

        // Flush with two ops issued; the input presented in the flush cycle is discarded.
        in_kind = 3'd0; in_data = 32'h1; in_amount = 5'd5; in_valid = 1'b1;
        step();
        in_kind = 3'd1; in_data = 32'h3; in_amount = 5'd0;
        step();
        flush = 1'b1; in_kind = 3'd3; in_data = 32'hF0F0_0000;
        step();
        check("flush_kill", 32'(out_valid_d[1]), 32'd0);
        flush = 1'b0; in_kind = 3'd1; in_data = 32'h100; in_amount = 5'd4;
        step();
        check("flush_discard", 32'(out_valid_d[1]), 32'd0);
        in_valid = 1'b0;
        step();
        check("flush_after_valid", 32'(out_valid_d[1]), 32'd1);
        check("flush_after_data", out_data_d[1], 32'h10);
        idle(6);

        // Randomized traffic with back-pressure, occasional flush and reset.
        for (int i = 0; i < 1500; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            in_kind   = 3'($urandom_range(0, 7));
            in_amount = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 5))
                0:       in_data = 32'h8000_0000;
                1:       in_data = 32'hFFFF_FFFF;
                default: in_data = $urandom();
            endcase
            step();
        end

        rst_n     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
